int_rat_param: RTL and testbench

Parametrised maze-solving controller. Depth-first search over a 2^CW × 2^CW grid held in an external synchronous maze memory, with a stack of configurable depth. Replays the solution path through a valid/ready handshake. Unlike the fixed 16×16 solver, it adds:
- an external memory port
- stack-overflow detection
- a path-length report
- repeatable, back-pressured path replay

---
 rtl/int_rat_if.sv | 35 +++
 rtl/int_rat_param.sv | 220 ++++++++++++++++++++++
 tb/tb_int_rat_param.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_rat_if.sv
// Maze-solver bus: control/status, maze memory port and move handshake.
// The master modport is the solver; the slave modport is the environment.
interface int_rat_if #(
  parameter int CW    = 4,
  parameter int DEPTH = 256,
  parameter int LW    = $clog2(DEPTH + 1)
);
  logic          start;
  logic          run;
  logic          mem_rdata;
  logic          move_ready;
  logic [CW-1:0] mem_x;
  logic [CW-1:0] mem_y;
  logic          mem_re;
  logic          mem_we;
  logic [1:0]    move;
  logic          move_valid;
  logic [LW-1:0] path_len;
  logic          busy;
  logic          done;
  logic          fail;
  logic          overflow;

  modport master (
    input  start, run, mem_rdata, move_ready,
    output mem_x, mem_y, mem_re, mem_we, move, move_valid,
           path_len, busy, done, fail, overflow
  );

  modport slave (
    output start, run, mem_rdata, move_ready,
    input  mem_x, mem_y, mem_re, mem_we, move, move_valid,
           path_len, busy, done, fail, overflow
  );
endinterface

// File: rtl/int_rat_param.sv
// Depth-first maze solver over a 2^CW square grid in external memory, with a
// move stack of DEPTH entries and repeatable back-pressured path replay.
module int_rat_param #(
  parameter int CW    = 4,
  parameter int DEPTH = 256,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input logic       clk,
  input logic       rst,
  int_rat_if.master bus
);

  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] MAXC = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_PROBE, S_EVAL, S_MOVE, S_BACK, S_DONE, S_FAIL, S_REPLAY
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_x, r_y, w_x, w_y;
  logic [LW-1:0] r_sp, w_sp, r_idx, w_idx, w_spm1;
  logic [1:0]    r_dir, w_dir;
  logic          r_done, r_fail, r_ovf, w_done, w_fail, w_ovf;
  logic [1:0]    r_stack [DEPTH];

  logic          w_push, w_restart, w_oob;
  logic [CW-1:0] w_nx, w_ny, w_bx, w_by;
  logic [1:0]    w_top, w_replay_mv;
  logic [CW-1:0] w_mem_x, w_mem_y;
  logic          w_mem_re, w_mem_we, w_move_valid;
  logic [1:0]    w_move;

  // Coordinate after one step in direction d (00 up, 01 right, 10 left, 11 down).
  function automatic logic [2*CW-1:0] f_step(input logic [CW-1:0] x,
                                             input logic [CW-1:0] y,
                                             input logic [1:0]    d);
    logic [CW-1:0] nx, ny;
    nx = x;
    ny = y;
    case (d)
      2'b00:   ny = y - CW'(1);
      2'b01:   nx = x + CW'(1);
      2'b10:   nx = x - CW'(1);
      default: ny = y + CW'(1);
    endcase
    return {nx, ny};
  endfunction

  assign {w_nx, w_ny} = f_step(r_x, r_y, r_dir);
  assign w_spm1       = r_sp - LW'(1);
  assign w_top        = r_stack[w_spm1[SW-1:0]];
  assign w_replay_mv  = r_stack[r_idx[SW-1:0]];
  // Opposite direction is the bitwise complement of the encoding.
  assign {w_bx, w_by} = f_step(r_x, r_y, ~w_top);

  always_comb begin
    case (r_dir)
      2'b00:   w_oob = (r_y == '0);
      2'b01:   w_oob = (r_x == MAXC);
      2'b10:   w_oob = (r_x == '0);
      default: w_oob = (r_y == MAXC);
    endcase
  end

  always_comb begin
    w_state      = r_state;
    w_x          = r_x;
    w_y          = r_y;
    w_sp         = r_sp;
    w_dir        = r_dir;
    w_idx        = r_idx;
    w_done       = r_done;
    w_fail       = r_fail;
    w_ovf        = r_ovf;
    w_push       = 1'b0;
    w_restart    = 1'b0;
    w_mem_x      = '0;
    w_mem_y      = '0;
    w_mem_re     = 1'b0;
    w_mem_we     = 1'b0;
    w_move       = 2'b00;
    w_move_valid = 1'b0;
    unique case (r_state)
      S_IDLE: w_restart = bus.start;
      S_INIT: begin
        w_mem_we = 1'b1;
        w_state  = S_PROBE;
      end
      S_PROBE: begin
        if (w_oob) begin
          if (r_dir == 2'd3) w_state = S_BACK;
          else               w_dir   = r_dir + 2'd1;
        end else begin
          w_mem_x  = w_nx;
          w_mem_y  = w_ny;
          w_mem_re = 1'b1;
          w_state  = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!bus.mem_rdata)      w_state = S_MOVE;
        else if (r_dir == 2'd3)  w_state = S_BACK;
        else begin
          w_dir   = r_dir + 2'd1;
          w_state = S_PROBE;
        end
      end
      S_MOVE: begin
        if (r_sp == LW'(DEPTH)) begin
          w_fail  = 1'b1;
          w_ovf   = 1'b1;
          w_state = S_FAIL;
        end else begin
          w_mem_we = 1'b1;
          w_mem_x  = w_nx;
          w_mem_y  = w_ny;
          w_x      = w_nx;
          w_y      = w_ny;
          w_push   = 1'b1;
          w_sp     = r_sp + LW'(1);
          w_dir    = 2'd0;
          if (w_nx == MAXC && w_ny == MAXC) begin
            w_done  = 1'b1;
            w_state = S_DONE;
          end else begin
            w_state = S_PROBE;
          end
        end
      end
      S_BACK: begin
        if (r_sp == '0) begin
          w_fail  = 1'b1;
          w_state = S_FAIL;
        end else begin
          w_sp    = w_spm1;
          w_x     = w_bx;
          w_y     = w_by;
          w_dir   = 2'd0;
          w_state = S_PROBE;
        end
      end
      S_DONE: begin
        if (bus.start) w_restart = 1'b1;
        else if (bus.run && r_sp != '0) begin
          w_idx   = '0;
          w_state = S_REPLAY;
        end
      end
      S_FAIL: w_restart = bus.start;
      S_REPLAY: begin
        w_move_valid = 1'b1;
        w_move       = w_replay_mv;
        if (bus.move_ready) begin
          if (r_idx == w_spm1) begin
            w_idx   = '0;
            w_state = S_DONE;
          end else begin
            w_idx = r_idx + LW'(1);
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
    if (w_restart) begin
      w_x     = '0;
      w_y     = '0;
      w_sp    = '0;
      w_dir   = 2'd0;
      w_done  = 1'b0;
      w_fail  = 1'b0;
      w_ovf   = 1'b0;
      w_state = S_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_sp    <= '0;
      r_dir   <= 2'd0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_sp    <= w_sp;
      r_dir   <= w_dir;
      r_idx   <= w_idx;
      r_done  <= w_done;
      r_fail  <= w_fail;
      r_ovf   <= w_ovf;
    end
  end

  // Move stack is pure storage; only sp qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[SW-1:0]] <= r_dir;
  end

  assign bus.mem_x      = w_mem_x;
  assign bus.mem_y      = w_mem_y;
  assign bus.mem_re     = w_mem_re;
  assign bus.mem_we     = w_mem_we;
  assign bus.move       = w_move;
  assign bus.move_valid = w_move_valid;
  assign bus.path_len   = r_sp;
  assign bus.busy       = (r_state == S_INIT)  || (r_state == S_PROBE) ||
                          (r_state == S_EVAL)  || (r_state == S_MOVE)  ||
                          (r_state == S_BACK)  || (r_state == S_REPLAY);
  assign bus.done       = r_done;
  assign bus.fail       = r_fail;
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_int_rat_param.sv
// Directed bench for int_rat_param: 4x4 solver (deep stack) and 4x4 solver
// with a 4-entry stack, each with its own synchronous maze memory model.
module tb_int_rat_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_rat_if #(.CW(2), .DEPTH(256)) if_a ();
  int_rat_if #(.CW(2), .DEPTH(4))   if_b ();

  int_rat_param #(.CW(2), .DEPTH(256)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  int_rat_param #(.CW(2), .DEPTH(4))   u_b (.clk(clk), .rst(rst), .bus(if_b));

  // Maze images: bit index = y*4 + x, 1 = wall/visited.
  logic [15:0] mem_a = '0, mem_b = '0, img_a = '0, img_b = '0;
  logic [15:0] wlog_a = '0;
  int          wcnt_a = 0;
  logic        ld_a = 1'b0, ld_b = 1'b0, rd_a = 1'b0, rd_b = 1'b0;

  always @(posedge clk) begin
    if (ld_a) begin
      mem_a  <= img_a;
      wlog_a <= '0;
      wcnt_a <= 0;
    end else begin
      if (if_a.mem_re) rd_a <= mem_a[{if_a.mem_y, if_a.mem_x}];
      if (if_a.mem_we) begin
        mem_a[{if_a.mem_y, if_a.mem_x}]  <= 1'b1;
        wlog_a[{if_a.mem_y, if_a.mem_x}] <= 1'b1;
        wcnt_a <= wcnt_a + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (ld_b) mem_b <= img_b;
    else begin
      if (if_b.mem_re) rd_b <= mem_b[{if_b.mem_y, if_b.mem_x}];
      if (if_b.mem_we) mem_b[{if_b.mem_y, if_b.mem_x}] <= 1'b1;
    end
  end

  assign if_a.mem_rdata = rd_a;
  assign if_b.mem_rdata = rd_b;

  // Solution through the empty 4x4 maze: R,R,R,D,L,L,L,D,R,R,R,D.
  logic [1:0] exp_mv [12] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10,
                              2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};

  int nvec = 0;
  int nerr = 0;

  task automatic load_a(input logic [15:0] img);
    img_a = img;
    ld_a  = 1'b1;
    @(negedge clk);
    ld_a  = 1'b0;
  endtask

  task automatic start_a();
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
  endtask

  task automatic wait_a(input string tag);
    int c;
    c = 0;
    while (!(if_a.done || if_a.fail) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    nvec++;
    if (c >= 3000) begin
      nerr++;
      $display("FAIL %s_timeout: no done/fail after %0d cycles", tag, c);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++;
    if ({if_a.busy, if_a.done, if_a.fail, if_a.overflow} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_status: got %b required 0000",
               {if_a.busy, if_a.done, if_a.fail, if_a.overflow});
    end
    nvec++;
    if ({if_a.mem_x, if_a.mem_y, if_a.mem_re, if_a.mem_we} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_mem: got %b required 000000",
               {if_a.mem_x, if_a.mem_y, if_a.mem_re, if_a.mem_we});
    end
    nvec++;
    if ({if_a.move_valid, if_a.move, if_a.path_len} !== 12'b0) begin
      nerr++;
      $display("FAIL reset_move: got %b required 0", {if_a.move_valid, if_a.move, if_a.path_len});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty();
    load_a(16'h0000);
    start_a();
    wait_a("empty");
    nvec++;
    if ({if_a.done, if_a.fail, if_a.overflow, if_a.busy} !== 4'b1000) begin
      nerr++;
      $display("FAIL empty_status: done/fail/ovf/busy=%b required 1000",
               {if_a.done, if_a.fail, if_a.overflow, if_a.busy});
    end
    nvec++;
    if (if_a.path_len !== 9'd12) begin
      nerr++;
      $display("FAIL empty_path_len: got %0d required 12", if_a.path_len);
    end
  endtask

  task automatic do_replay(input bit bp, input string tag);
    int k, c;
    bit rdy;
    k = 0;
    c = 0;
    if_a.move_ready = !bp;
    if_a.run = 1'b1;
    @(negedge clk);
    if_a.run = 1'b0;
    while (k < 12 && c < 100) begin
      rdy = bp ? ((c < 3) ? 1'b0 : ((c - 3) % 2 == 0)) : 1'b1;
      if_a.move_ready = rdy;
      nvec++;
      if (if_a.move_valid !== 1'b1 || if_a.move !== exp_mv[k]) begin
        nerr++;
        $display("FAIL %s_move%0d: valid=%b move=%b required valid=1 move=%b",
                 tag, k, if_a.move_valid, if_a.move, exp_mv[k]);
      end
      if (rdy) k++;
      c++;
      @(negedge clk);
    end
    if_a.move_ready = 1'b0;
    nvec++;
    if (k != 12) begin
      nerr++;
      $display("FAIL %s_count: accepted %0d required 12", tag, k);
    end
    nvec++;
    if ({if_a.move_valid, if_a.done, if_a.busy} !== 3'b010) begin
      nerr++;
      $display("FAIL %s_end: valid/done/busy=%b required 010", tag,
               {if_a.move_valid, if_a.done, if_a.busy});
    end
  endtask

  task automatic test_walled();
    load_a(16'hFFFE);
    start_a();
    wait_a("walled");
    nvec++;
    if ({if_a.done, if_a.fail, if_a.overflow} !== 3'b010) begin
      nerr++;
      $display("FAIL walled_status: done/fail/ovf=%b required 010",
               {if_a.done, if_a.fail, if_a.overflow});
    end
    nvec++;
    if (if_a.path_len !== 9'd0) begin
      nerr++;
      $display("FAIL walled_path_len: got %0d required 0", if_a.path_len);
    end
    nvec++;
    if (wcnt_a !== 1 || wlog_a !== 16'h0001) begin
      nerr++;
      $display("FAIL walled_writes: count=%0d cells=%h required 1 / 0001", wcnt_a, wlog_a);
    end
  endtask

  task automatic test_dead_end();
    // Walls at (1,1),(2,1),(3,1),(0,2) -> bits 5,6,7,8.
    load_a(16'h01E0);
    start_a();
    wait_a("deadend");
    nvec++;
    if ({if_a.done, if_a.fail, if_a.overflow} !== 3'b010) begin
      nerr++;
      $display("FAIL deadend_status: done/fail/ovf=%b required 010",
               {if_a.done, if_a.fail, if_a.overflow});
    end
    nvec++;
    if (if_a.path_len !== 9'd0) begin
      nerr++;
      $display("FAIL deadend_path_len: got %0d required 0", if_a.path_len);
    end
    nvec++;
    if (wcnt_a !== 5 || wlog_a !== 16'h001F) begin
      nerr++;
      $display("FAIL deadend_writes: count=%0d cells=%h required 5 / 001f", wcnt_a, wlog_a);
    end
  endtask

  task automatic test_overflow();
    int c;
    img_b = 16'h0000;
    ld_b  = 1'b1;
    @(negedge clk);
    ld_b  = 1'b0;
    if_b.start = 1'b1;
    @(negedge clk);
    if_b.start = 1'b0;
    c = 0;
    while (!(if_b.done || if_b.fail) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    nvec++;
    if ({if_b.done, if_b.fail, if_b.overflow} !== 3'b011) begin
      nerr++;
      $display("FAIL ovf_status: done/fail/ovf=%b required 011",
               {if_b.done, if_b.fail, if_b.overflow});
    end
    nvec++;
    if (if_b.path_len !== 3'd4) begin
      nerr++;
      $display("FAIL ovf_path_len: got %0d required 4", if_b.path_len);
    end
  endtask

  task automatic test_async_reset();
    int c;
    load_a(16'h0000);
    start_a();
    c = 0;
    while (!(if_a.path_len == 9'd3 && if_a.mem_re) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    nvec++;
    if (c >= 3000) begin
      nerr++;
      $display("FAIL arst_reach_probe: no probe at path_len 3 after %0d cycles", c);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if ({if_a.busy, if_a.mem_re, if_a.mem_we, if_a.mem_x, if_a.mem_y, if_a.path_len} !== 16'b0) begin
      nerr++;
      $display("FAIL arst_outputs: busy/re/we/x/y/len=%b required 0",
               {if_a.busy, if_a.mem_re, if_a.mem_we, if_a.mem_x, if_a.mem_y, if_a.path_len});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_a(16'h0000);
    start_a();
    wait_a("arst_rerun");
    nvec++;
    if (if_a.done !== 1'b1 || if_a.path_len !== 9'd12) begin
      nerr++;
      $display("FAIL arst_rerun: done=%b path_len=%0d required done=1 path_len=12",
               if_a.done, if_a.path_len);
    end
  endtask

  initial begin
    if_a.start = 1'b0; if_a.run = 1'b0; if_a.move_ready = 1'b0;
    if_b.start = 1'b0; if_b.run = 1'b0; if_b.move_ready = 1'b1;
    test_reset();
    test_empty();
    do_replay(1'b0, "replay");
    do_replay(1'b1, "bp_replay");
    do_replay(1'b0, "replay_again");
    test_walled();
    test_dead_end();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
